uart_rx_buffer: RTL

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_buffer_if.sv | 18 +
 rtl/uart_byte_fifo.sv | 63 ++++++
 rtl/uart_rx_buffer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and constants for the UART receive buffer.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS   = 8;

    localparam int ERR_OVERRUN = 0;
    localparam int ERR_FRAME   = 1;
    localparam int ERR_PARITY  = 2;
    localparam int ERR_FLAGS   = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_buffer_if
// Brief   : Four-phase CPU read handshake for the UART receive buffer.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_rx_buffer_if;
    import uart_pkg::*;

    logic                 uartReadReq;
    logic                 uartReadAck;
    logic [DATA_BITS-1:0] uartReadData;

    modport master (output uartReadReq, input  uartReadAck, input  uartReadData);
    modport slave  (input  uartReadReq, output uartReadAck, output uartReadData);

endinterface
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_byte_fifo
// Brief   : Power-of-two byte FIFO; a push into a full FIFO is dropped unless
//           a pop happens in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       push,
    input  wire logic [DATA_BITS-1:0]       push_data,
    input  wire logic                       pop,
    output logic      [DATA_BITS-1:0]       head_data,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so wrap-around is free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_buffer
// Brief   : 8N1 UART receiver with byte FIFO, four-phase CPU read port and
//           sticky error flags. Define UART_RX_PARITY_EN for 8E1 framing.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 16
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   rxSerial,
    uart_rx_buffer_if.slave             rd,
    input  wire logic                   clearErr,
    output logic [$clog2(DEPTH):0]      rxCount,
    output logic                        overrunErr,
    output logic                        frameErr,
    output logic                        parityErr
);
    localparam int CNT_W = 16;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    logic                 sync_meta;
    logic                 sync_line;
    logic                 line_prev;
    rx_state_t            state;
    logic [CNT_W-1:0]     bit_timer;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 push_pending;
    logic                 frame_evt;
    logic                 parity_evt;
    logic                 sample;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
    logic [ERR_FLAGS-1:0] err_set;
    logic [ERR_FLAGS-1:0] err_flags;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad;
`else
    assign parity_evt = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_meta <= rxSerial;
            sync_line <= sync_meta;
            line_prev <= sync_line;
        end
    end

    assign sample = (bit_timer == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            bit_timer    <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            push_pending <= 1'b0;
            frame_evt    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
            parity_evt   <= 1'b0;
`endif
        end else begin
            push_pending <= 1'b0;
            frame_evt    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_evt   <= 1'b0;
`endif
            if (!sample) bit_timer <= bit_timer - CNT_W'(1);
            case (state)
                ST_IDLE: begin
                    if (line_prev && !sync_line) begin
                        state     <= ST_START;
                        bit_timer <= HALF_BIT;
                    end
                end
                ST_START: begin
                    if (sample) begin
                        // A line already back high mid start bit is a glitch.
                        state     <= sync_line ? ST_IDLE : ST_DATA;
                        bit_timer <= FULL_BIT;
                        bit_idx   <= '0;
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        shift_reg <= {sync_line, shift_reg[DATA_BITS-1:1]};
                        bit_timer <= FULL_BIT;
                        bit_idx   <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (sample) begin
                        parity_bad <= (sync_line != even_parity(shift_reg));
                        parity_evt <= (sync_line != even_parity(shift_reg));
                        bit_timer  <= FULL_BIT;
                        state      <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (sample) begin
`ifdef UART_RX_PARITY_EN
                        push_pending <= sync_line && !parity_bad;
`else
                        push_pending <= sync_line;
`endif
                        frame_evt    <= !sync_line;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_pending),
        .push_data (shift_reg),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rxCount)
    );

    assign fifo_pop = rd.uartReadReq && !rd.uartReadAck && !fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd.uartReadAck  <= 1'b0;
            rd.uartReadData <= '0;
        end else if (fifo_pop) begin
            rd.uartReadAck  <= 1'b1;
            rd.uartReadData <= fifo_head;
        end else if (!rd.uartReadReq) begin
            rd.uartReadAck  <= 1'b0;
        end
    end

    assign err_set[ERR_OVERRUN] = push_pending && fifo_full && !fifo_pop;
    assign err_set[ERR_FRAME]   = frame_evt;
    assign err_set[ERR_PARITY]  = parity_evt;

    // New events are OR-ed in after the clear so they survive a coincident clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_flags <= '0;
        end else begin
            err_flags <= (clearErr ? '0 : err_flags) | err_set;
        end
    end

    assign overrunErr = err_flags[ERR_OVERRUN];
    assign frameErr   = err_flags[ERR_FRAME];
    assign parityErr  = err_flags[ERR_PARITY];

endmodule
`default_nettype wire
